// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/level controller for the async FIFO.
// Tracks the binary/gray write pointer and derives full, almost-full, level and overflow status.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH   = 7,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic                  wovf_clr,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray_full;
  logic [PW-1:0] wlevel_next;
  logic          wfull_next;
  logic          walmost_full_next;
  logic          woverflow_next;

  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDR_WIDTH-1:0];

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Full when the next write pointer sits one lap ahead of the read pointer.
  assign rgray_full = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};

  always_comb begin
    wbin_next         = wbin + PW'(wen);
    wgray_next        = wbin_next ^ (wbin_next >> 1);
    wfull_next        = (wgray_next == rgray_full);
    wlevel_next       = wbin_next - rbin;
    walmost_full_next = (wlevel_next >= AFULL_T);
    woverflow_next    = (winc & wfull) | (woverflow & ~wovf_clr);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wlevel       <= wlevel_next;
      woverflow    <= woverflow_next;
    end
  end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-domain pointer and full-flag controller for the async FIFO. It consumes the read pointer that has been synchronised into the write clock domain, gray-coded, and drives the outputs below:

- write address and write enable for the dual-port RAM;
- the gray-coded write pointer sent to the read-side synchroniser;
- full, almost-full and fill-level status;
- a sticky overflow flag.

It sits between the write-side user logic and the RAM/synchroniser pair, entirely in the write clock domain.

## Interface

- ADDR_WIDTH, 7, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 2**ADDR_WIDTH-2, fill level at or above which walmost_full asserts; legal range 1..2**ADDR_WIDTH.

- wclk  input  1  write-domain clock; all state is updated on its rising edge.
- wrst  input  1  asynchronous, active-high reset.
- winc  input  1  write request from user logic.
- wovf_clr  input  1  clears woverflow.
- wq2_rptr  input  ADDR_WIDTH+1  read pointer (gray), already synchronised to wclk.
- wen  output  1  RAM write enable; combinational: winc & ~wfull.
- waddr  output  ADDR_WIDTH  RAM write address; the low bits of the binary write pointer.
- wptr  output  ADDR_WIDTH+1  gray write pointer, registered, to the read-side synchroniser.
- wfull  output  1  FIFO full, registered.
- walmost_full  output  1  registered; asserted when the level is at or above AFULL_THRESH.
- wlevel  output  ADDR_WIDTH+1  registered fill level, range 0..2**ADDR_WIDTH.
- woverflow  output  1  sticky; set by a write attempt while full.

## Operation

- State registers:
  - wbin: binary write pointer, ADDR_WIDTH+1 bits;
  - wptr: gray write pointer;
  - wfull, walmost_full, wlevel, woverflow.
- Reset (wrst=1): all registers clear to 0 immediately, without waiting for a wclk edge. All outputs therefore read 0, except wen, which is winc & ~wfull = winc.
- Accepted write: winc & ~wfull.
  - wbin_next = wbin + accepted, modulo 2**(ADDR_WIDTH+1). The pointer wraps naturally; there is no special case.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- Read pointer conversion: rbin = gray-to-binary of wq2_rptr (XOR-prefix from the MSB down), combinational.
- Full detection: wfull_next = (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
  - Computed from the next pointer, so wfull asserts on the same edge that stores the last free entry.
- Level: wlevel_next = wbin_next − rbin, modulo 2**(ADDR_WIDTH+1). It never exceeds 2**ADDR_WIDTH.
- Almost full: walmost_full_next = (wlevel_next >= AFULL_THRESH).
- Overflow:
  - woverflow_next = (winc & wfull) | (woverflow & ~wovf_clr).
  - If a set and a clear occur in the same cycle, the set wins.
- A write attempted while full is dropped: wen=0 and no pointer change.
- Status is pessimistic.
  - Read progress is seen only through wq2_rptr, so wfull and wlevel may overstate occupancy.
  - They never understate it.

## Timing

- wen has zero latency: it is combinational from winc and the current wfull.
- waddr, wptr, wfull, walmost_full and wlevel update on the wclk edge at which a write is accepted. This is 1 cycle after winc is sampled.
- A change on wq2_rptr is reflected in wfull, walmost_full and wlevel one edge later.
  - End-to-end read-to-full-clear delay = read-domain pointer update + 2 wclk of synchroniser + 1 wclk here.
- wfull=1 with wq2_rptr advancing in the same cycle:
  - that cycle's winc is still blocked (wfull is registered);
  - the write is accepted in the following cycle.
- Deasserting reset mid-operation resumes from the all-zero state. No partial pointer survives reset.
- Only gray values ever appear on wptr, so exactly 1 bit changes per accepted write.

## Test plan

Bench configuration: ADDR_WIDTH=3 (depth 8), AFULL_THRESH=6, wq2_rptr=0 unless stated.

- **Reset:** assert wrst between clock edges after 5 writes.
  - All registered outputs go to 0 before the next edge, and woverflow clears.
  - After release, the first write produces waddr=0 → 1 and wptr=4'b0001.
- **Fill:** 8 back-to-back winc.
  - wptr follows 0,1,3,2,6,7,5,4,12 (gray).
  - walmost_full rises on the 6th accepting edge.
  - wfull and wlevel=8 appear on the 8th edge.
- **Overflow:** hold winc=1 while full.
  - wen=0, wptr stays 4'b1100 and waddr stays 0.
  - woverflow=1 after 1 edge.
  - Pulse wovf_clr with winc=1: woverflow stays 1. Pulse it with winc=0: woverflow clears.
- **Drain while full:** set wq2_rptr = gray 1 (4'b0001).
  - wfull=0, wlevel=7 and walmost_full=1 on the next edge.
  - A write issued in the cycle wq2_rptr changes is blocked; the same write in the next cycle is accepted and wfull returns to 1.
- **Wrap:** 20 writes, with wq2_rptr tracking 3 entries behind wptr.
  - wfull never asserts and wlevel is constant at 3.
  - waddr wraps 7→0, and wptr passes through 4'b1000 → 4'b0000 at the 16th write.
- **Threshold edge:** wlevel oscillates 5↔6 via alternating writes and read-pointer advances.
  - walmost_full toggles in lockstep, one edge after each wlevel change source.
